// File: rtl/dig_clock_pkg.sv
// Shared constants for the clock display: segment patterns, digit slots,
// field widths and range limits, plus the BCD-digit to segment encoder.
package dig_clock_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    // Digit slot numbering; slot 0 is the rightmost digit on the board.
    localparam logic [1:0] DIG_RIGHT_UNITS = 2'd0;
    localparam logic [1:0] DIG_RIGHT_TENS  = 2'd1;
    localparam logic [1:0] DIG_LEFT_UNITS  = 2'd2;
    localparam logic [1:0] DIG_LEFT_TENS   = 2'd3;

    // Exclusive upper bounds for each field.
    localparam logic [5:0] LIMIT_MIN_SEC = 6'd60;
    localparam logic [5:0] LIMIT_HR      = 6'd24;

    // Active-low {g,f,e,d,c,b,a} patterns.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Map one BCD digit to its segment pattern; non-decimal codes go dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = SEG_DIGIT[0];
            4'd1:    code = SEG_DIGIT[1];
            4'd2:    code = SEG_DIGIT[2];
            4'd3:    code = SEG_DIGIT[3];
            4'd4:    code = SEG_DIGIT[4];
            4'd5:    code = SEG_DIGIT[5];
            4'd6:    code = SEG_DIGIT[6];
            4'd7:    code = SEG_DIGIT[7];
            4'd8:    code = SEG_DIGIT[8];
            4'd9:    code = SEG_DIGIT[9];
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/dig_clock_display_bin2bcd_2d.sv
// Two-digit binary to BCD split for one display field, with a range flag.
module bin2bcd_2d
    import dig_clock_pkg::*;
(
    input  logic [5:0] value,
    input  logic [5:0] limit,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       invalid
);

    // Divide by ten for the digits and compare against the field's limit.
    always_comb begin
        tens    = 4'(value / 6'd10);
        units   = 4'(value % 6'd10);
        invalid = (value >= limit);
    end

endmodule

// File: rtl/dig_clock_display.sv
// Four-digit multiplexed 7-segment driver for HH:MM / MM:SS with a blinking
// colon. Inputs are snapshotted once per frame so a frame never mixes values.
module dig_clock_display
    import dig_clock_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_DIV  = 50000000,
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEC_W-1:0]  seconds,
    input  logic [MIN_W-1:0]  minutes,
    input  logic [HR_W-1:0]   hours,
    input  logic              show_seconds,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [1:0]         digit_sel_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               colon_on_r;

    logic [SEC_W-1:0]   sec_r;
    logic [MIN_W-1:0]   min_r;
    logic [HR_W-1:0]    hr_r;
    logic               show_sec_r;

    logic [3:0]         an_r;
    logic [6:0]         seg_r;
    logic               dp_r;

    logic               scan_tc_s;
    logic               blink_tc_s;
    logic               snapshot_s;

    logic [5:0]         left_val_s;
    logic [5:0]         left_lim_s;
    logic [5:0]         right_val_s;
    logic [3:0]         left_tens_s;
    logic [3:0]         left_units_s;
    logic               left_inv_s;
    logic [3:0]         right_tens_s;
    logic [3:0]         right_units_s;
    logic               right_inv_s;

    logic [3:0]         an_next_s;
    logic [6:0]         seg_next_s;
    logic               dp_next_s;

    // Terminal-count decodes; the snapshot lands as the last digit finishes.
    always_comb begin
        scan_tc_s  = (scan_cnt_r == SCAN_W'(SCAN_DIV - 1));
        blink_tc_s = (blink_cnt_r == BLINK_W'(BLINK_DIV - 1));
        snapshot_s = scan_tc_s && (digit_sel_r == DIG_LEFT_TENS);
    end

    // Digit dwell counter and digit selector.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_r  <= {SCAN_W{1'b0}};
            digit_sel_r <= 2'd0;
        end else if (scan_tc_s) begin
            scan_cnt_r  <= {SCAN_W{1'b0}};
            digit_sel_r <= digit_sel_r + 2'd1;
        end else begin
            scan_cnt_r  <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // Colon half-period counter; colon starts lit after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
            colon_on_r  <= 1'b1;
        end else if (blink_tc_s) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
            colon_on_r  <= ~colon_on_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    // Frame shadow registers, loaded only at the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            sec_r      <= {SEC_W{1'b0}};
            min_r      <= {MIN_W{1'b0}};
            hr_r       <= {HR_W{1'b0}};
            show_sec_r <= 1'b0;
        end else if (snapshot_s) begin
            sec_r      <= seconds;
            min_r      <= minutes;
            hr_r       <= hours;
            show_sec_r <= show_seconds;
        end
    end

    // Pick which quantities feed the left and right fields.
    always_comb begin
        if (show_sec_r) begin
            left_val_s  = min_r;
            left_lim_s  = LIMIT_MIN_SEC;
            right_val_s = sec_r;
        end else begin
            left_val_s  = {1'b0, hr_r};
            left_lim_s  = LIMIT_HR;
            right_val_s = min_r;
        end
    end

    bin2bcd_2d u_left (
        .value   (left_val_s),
        .limit   (left_lim_s),
        .tens    (left_tens_s),
        .units   (left_units_s),
        .invalid (left_inv_s)
    );

    bin2bcd_2d u_right (
        .value   (right_val_s),
        .limit   (LIMIT_MIN_SEC),
        .tens    (right_tens_s),
        .units   (right_units_s),
        .invalid (right_inv_s)
    );

    // Segment pattern, anode pattern and colon for the selected digit.
    always_comb begin
        seg_next_s = SEG_BLANK;
        an_next_s  = 4'b1111;
        case (digit_sel_r)
            DIG_RIGHT_UNITS: begin
                an_next_s  = 4'b1110;
                seg_next_s = right_inv_s ? SEG_DASH : seg_encode(right_units_s);
            end
            DIG_RIGHT_TENS: begin
                an_next_s  = 4'b1101;
                seg_next_s = right_inv_s ? SEG_DASH : seg_encode(right_tens_s);
            end
            DIG_LEFT_UNITS: begin
                an_next_s  = 4'b1011;
                seg_next_s = left_inv_s ? SEG_DASH : seg_encode(left_units_s);
            end
            DIG_LEFT_TENS: begin
                an_next_s = 4'b0111;
                if (left_inv_s) begin
                    seg_next_s = SEG_DASH;
                end else if (BLANK_LEAD && !show_sec_r && (left_tens_s == 4'd0)) begin
                    seg_next_s = SEG_BLANK;
                end else begin
                    seg_next_s = seg_encode(left_tens_s);
                end
            end
            default: begin
                an_next_s  = 4'b1111;
                seg_next_s = SEG_BLANK;
            end
        endcase
        dp_next_s = ~((digit_sel_r == DIG_LEFT_UNITS) && colon_on_r);
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r  <= 4'b1111;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_next_s;
            seg_r <= seg_next_s;
            dp_r  <= dp_next_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_dig_clock_display.sv
// Bench for dig_clock_display: three instances (lead blanking on/off, and a
// shorter blink period so colon and digit 2 overlap) checked every cycle
// against a cycle-count model, plus literal expectations for key scenarios.
module tb_dig_clock_display;

    localparam int SCAN    = 4;
    localparam int BLINK   = 8;
    localparam int BLINK_B = 6;

    logic       clk;
    logic       reset;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       show_seconds;

    logic [3:0] an_a, an_n, an_b;
    logic [6:0] seg_a, seg_n, seg_b;
    logic       dp_a, dp_n, dp_b;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dig_clock_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .BLANK_LEAD(1'b1)) dut (
        .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
        .show_seconds(show_seconds), .an(an_a), .seg(seg_a), .dp(dp_a));

    dig_clock_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .BLANK_LEAD(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
        .show_seconds(show_seconds), .an(an_n), .seg(seg_n), .dp(dp_n));

    dig_clock_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK_B), .BLANK_LEAD(1'b1)) dut_b6 (
        .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
        .show_seconds(show_seconds), .an(an_b), .seg(seg_b), .dp(dp_b));

    // ---------------- reference model ----------------
    function automatic logic [6:0] digit_code(input int v);
        case (v)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int d, input int s_sec, input int s_min,
                                             input int s_hr, input bit s_show, input bit blank);
        int lv, rv, llim;
        lv   = s_show ? s_min : s_hr;
        llim = s_show ? 60 : 24;
        rv   = s_show ? s_sec : s_min;
        if (d == 0) return (rv >= 60) ? 7'b0111111 : digit_code(rv % 10);
        if (d == 1) return (rv >= 60) ? 7'b0111111 : digit_code(rv / 10);
        if (lv >= llim) return 7'b0111111;
        if (d == 2) return digit_code(lv % 10);
        if (blank && !s_show && (lv / 10 == 0)) return 7'b1111111;
        return digit_code(lv / 10);
    endfunction

    bit         mvalid;
    int         m;
    int         sh_sec, sh_min, sh_hr;
    bit         sh_show;
    logic [3:0] e_an;
    logic [6:0] e_seg_a, e_seg_n;
    logic       e_dp_a, e_dp_b;

    // Model: m = clean cycles since reset; the outputs after an edge show the
    // digit/frame state that held before that edge.
    initial begin
        mvalid = 1'b0;
        m = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                mvalid  = 1'b1;
                m       = 0;
                sh_sec  = 0; sh_min = 0; sh_hr = 0; sh_show = 1'b0;
                e_an    = 4'b1111;
                e_seg_a = 7'b1111111;
                e_seg_n = 7'b1111111;
                e_dp_a  = 1'b1;
                e_dp_b  = 1'b1;
            end else if (mvalid) begin
                int d;
                d       = (m / SCAN) % 4;
                e_an    = ~(4'b0001 << d);
                e_seg_a = model_seg(d, sh_sec, sh_min, sh_hr, sh_show, 1'b1);
                e_seg_n = model_seg(d, sh_sec, sh_min, sh_hr, sh_show, 1'b0);
                e_dp_a  = !((d == 2) && (((m / BLINK) % 2) == 0));
                e_dp_b  = !((d == 2) && (((m / BLINK_B) % 2) == 0));
                if ((m % (4 * SCAN)) == (4 * SCAN - 1)) begin
                    sh_sec  = int'(seconds);
                    sh_min  = int'(minutes);
                    sh_hr   = int'(hours);
                    sh_show = show_seconds;
                end
                m = m + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        if (mvalid) begin
            check("an_a", 32'(an_a), 32'(e_an));
            check("an_n", 32'(an_n), 32'(e_an));
            check("an_b", 32'(an_b), 32'(e_an));
            check("seg_a", 32'(seg_a), 32'(e_seg_a));
            check("seg_n", 32'(seg_n), 32'(e_seg_n));
            check("seg_b", 32'(seg_b), 32'(e_seg_a));
            check("dp_a", 32'(dp_a), 32'(e_dp_a));
            check("dp_n", 32'(dp_n), 32'(e_dp_a));
            check("dp_b", 32'(dp_b), 32'(e_dp_b));
        end
    endtask

    // Tick until the main instance lights the requested anode pattern.
    task automatic wait_an(input logic [3:0] target, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (an_a === target) found = 1'b1;
        end
        if (!found) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s timeout waiting an actual=%0b required=%0b", name, an_a, target);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int low_a, low_b;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        seconds = 6'd0; minutes = 6'd0; hours = 5'd0; show_seconds = 1'b0;

        repeat (3) tick();
        check("rst_an", 32'(an_a), 32'(4'b1111));
        check("rst_seg", 32'(seg_a), 32'(7'b1111111));
        check("rst_dp", 32'(dp_a), 32'(1'b1));

        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_an", 32'(an_a), 32'(4'b1110));
            check("post_rst_seg", 32'(seg_a), 32'(7'b1000000));
        end

        // Reset while digit 2 is being scanned.
        wait_an(4'b1011, "midscan");
        reset = 1'b1;
        tick();
        check("mid_rst_an", 32'(an_a), 32'(4'b1111));
        check("mid_rst_seg", 32'(seg_a), 32'(7'b1111111));
        check("mid_rst_dp", 32'(dp_a), 32'(1'b1));
        reset = 1'b0;
        tick();
        check("mid_rst_restart", 32'(an_a), 32'(4'b1110));

        // 13:45
        hours = 5'd13; minutes = 6'd45; show_seconds = 1'b0;
        repeat (40) tick();
        wait_an(4'b0111, "hm_d3"); check("hm_d3", 32'(seg_a), 32'(7'b1111001));
        wait_an(4'b1011, "hm_d2"); check("hm_d2", 32'(seg_a), 32'(7'b0110000));
        wait_an(4'b1101, "hm_d1"); check("hm_d1", 32'(seg_a), 32'(7'b0011001));
        wait_an(4'b1110, "hm_d0"); check("hm_d0", 32'(seg_a), 32'(7'b0010010));

        // Leading-zero blanking
        hours = 5'd5;
        repeat (40) tick();
        wait_an(4'b0111, "blank");
        check("blank_on", 32'(seg_a), 32'(7'b1111111));
        check("blank_off", 32'(seg_n), 32'(7'b1000000));

        // Out-of-range minutes in MM:SS view
        minutes = 6'd60; seconds = 6'd7; show_seconds = 1'b1;
        repeat (40) tick();
        wait_an(4'b0111, "inv_d3"); check("inv_d3", 32'(seg_a), 32'(7'b0111111));
        wait_an(4'b1011, "inv_d2"); check("inv_d2", 32'(seg_a), 32'(7'b0111111));
        wait_an(4'b1101, "inv_d1"); check("inv_d1", 32'(seg_a), 32'(7'b1000000));
        wait_an(4'b1110, "inv_d0"); check("inv_d0", 32'(seg_a), 32'(7'b1111000));

        // Mid-frame input change must wait for the next frame
        hours = 5'd13; minutes = 6'd12; show_seconds = 1'b0;
        repeat (40) tick();
        wait_an(4'b1101, "tear_d1");
        check("tear_old_d1", 32'(seg_a), 32'(7'b1111001));
        minutes = 6'd34;
        wait_an(4'b1110, "tear_d0"); check("tear_new_d0", 32'(seg_a), 32'(7'b0011001));
        wait_an(4'b1101, "tear_d1b"); check("tear_new_d1", 32'(seg_a), 32'(7'b0110000));

        // Colon over 32 cycles from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        low_a = 0;
        low_b = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (dp_a == 1'b0) low_a++;
            if (dp_b == 1'b0) low_b++;
        end
        check("dp_low_cnt_a", 32'(low_a), 32'd0);
        check("dp_low_cnt_b", 32'(low_b), 32'd4);

        // Randomized inputs with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                seconds      = 6'($urandom_range(0, 63));
                minutes      = 6'($urandom_range(0, 63));
                hours        = 5'($urandom_range(0, 31));
                show_seconds = 1'($urandom_range(0, 1));
            end
            reset = ($urandom_range(0, 79) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
